disp_share_arbiter: RTL and testbench

//  Shares the single 4-digit hex display among N_REQ independent requesters.

---
 rtl/disp_share_arbiter.sv | 173 +++++++++++++++++
 tb/tb_disp_share_arbiter.sv | 104 ++++++++++
 2 files changed

// File: rtl/disp_share_arbiter.sv
// Round-robin sharing of one 4-digit hex display among N_REQ sources,
// with a minimum dwell per grant and leading-zero blanking of the shown word.

// Per-source lane: leading-zero blank mask for that source's word.
module disp_share_lane #(
  parameter int LZ_BLANK = 1
) (
  input  logic [15:0] word,
  output logic [3:0]  blank
);
  logic d3, d2, d1;

  always_comb begin
    d3 = (word[15:12] == 4'h0);
    d2 = d3 && (word[11:8] == 4'h0);
    d1 = d2 && (word[7:4] == 4'h0);
    if (LZ_BLANK != 0) blank = {d3, d2, d1, 1'b0};
    else               blank = 4'h0;
  end
endmodule

module disp_share_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DWELL    = 8,
  parameter int DWELL_W  = 4,
  parameter int LZ_BLANK = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req,
  input  logic [16*N_REQ-1:0]  req_data,
  output logic [N_REQ-1:0]     gnt,
  output logic [2:0]           owner,
  output logic [15:0]          disp_data,
  output logic [3:0]           disp_blank,
  output logic                 switch_p
);

  typedef enum logic {S_IDLE, S_GRANT} state_t;

  state_t               state, nxt_state;
  logic [DWELL_W-1:0]   dwell_cnt, nxt_dwell;
  logic [2:0]           rr_ptr, nxt_rr;
  logic [N_REQ-1:0]     nxt_gnt;
  logic [2:0]           nxt_owner;
  logic [15:0]          nxt_data;
  logic [3:0]           nxt_blank;
  logic                 nxt_sw;

  logic [N_REQ-1:0][15:0] words;
  logic [N_REQ-1:0][3:0]  lane_blank;

  logic [2:0]           pick;
  logic                 pick_vld;
  logic [N_REQ-1:0]     pick_oh;
  logic                 new_grant;
  logic                 own_req, other_req, dwell_zero;
  logic [N_REQ-1:0]     sel_oh;
  logic [15:0]          sel_word;
  logic [3:0]           sel_blank;
  logic [3:0]           idx;

  assign words = req_data;

  for (genvar k = 0; k < N_REQ; k++) begin : g_lane
    disp_share_lane #(.LZ_BLANK(LZ_BLANK)) u_lane (
      .word  (words[k]),
      .blank (lane_blank[k])
    );
  end

  // gnt is the owner's one-hot while granted, so it doubles as the owner mask.
  assign own_req    = |(req & gnt);
  assign other_req  = |(req & ~gnt);
  assign dwell_zero = (dwell_cnt == '0);

  // rr_ptr is always owner+1 while granted, so one search serves both
  // the idle/release case and the rotate-from-o+1 case.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    idx      = '0;
    for (int i = 0; i < N_REQ; i++) begin
      idx = {1'b0, rr_ptr} + 4'(i);
      if (idx >= 4'(N_REQ)) idx = idx - 4'(N_REQ);
      for (int k = 0; k < N_REQ; k++) begin
        if (!pick_vld && req[k] && (idx == 4'(k))) begin
          pick     = 3'(k);
          pick_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    pick_oh = '0;
    for (int k = 0; k < N_REQ; k++) pick_oh[k] = pick_vld && (pick == 3'(k));
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      gnt        <= '0;
      owner      <= '0;
      disp_data  <= 16'h0000;
      disp_blank <= 4'hF;
      switch_p   <= 1'b0;
      dwell_cnt  <= '0;
      rr_ptr     <= '0;
    end else begin
      state      <= nxt_state;
      gnt        <= nxt_gnt;
      owner      <= nxt_owner;
      disp_data  <= nxt_data;
      disp_blank <= nxt_blank;
      switch_p   <= nxt_sw;
      dwell_cnt  <= nxt_dwell;
      rr_ptr     <= nxt_rr;
    end
  end

  // Next-state logic
  always_comb begin
    nxt_state = state;
    new_grant = 1'b0;
    case (state)
      S_IDLE: begin
        if (|req) begin
          nxt_state = S_GRANT;
          new_grant = 1'b1;
        end
      end
      S_GRANT: begin
        if (!own_req) begin
          // Release ignores dwell; hand over on the same edge if anyone waits.
          if (other_req) new_grant = 1'b1;
          else           nxt_state = S_IDLE;
        end else if (dwell_zero && other_req) begin
          new_grant = 1'b1;
        end
      end
      default: nxt_state = S_IDLE;
    endcase
  end

  // Output / datapath logic
  always_comb begin
    sel_oh    = new_grant ? pick_oh : gnt;
    sel_word  = '0;
    sel_blank = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (sel_oh[k]) begin
        sel_word  = sel_word  | words[k];
        sel_blank = sel_blank | lane_blank[k];
      end
    end

    nxt_gnt   = (nxt_state == S_GRANT) ? sel_oh : '0;
    nxt_owner = new_grant ? pick : owner;
    nxt_data  = (nxt_state == S_GRANT) ? sel_word : disp_data;
    nxt_blank = (nxt_state == S_GRANT) ? sel_blank : 4'hF;
    nxt_sw    = new_grant;

    if (new_grant)        nxt_dwell = DWELL_W'(DWELL - 1);
    else if (!dwell_zero) nxt_dwell = dwell_cnt - DWELL_W'(1);
    else                  nxt_dwell = dwell_cnt;

    nxt_rr = rr_ptr;
    if (new_grant) nxt_rr = (pick == 3'(N_REQ - 1)) ? 3'd0 : pick + 3'd1;
  end

endmodule

// File: tb/tb_disp_share_arbiter.sv
// Directed scoreboard bench for disp_share_arbiter (N_REQ=4, DWELL=8, LZ_BLANK=1).
module tb_disp_share_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [63:0] req_data = '0;
  logic [3:0]  gnt;
  logic [2:0]  owner;
  logic [15:0] disp_data;
  logic [3:0]  disp_blank;
  logic        switch_p;

  typedef struct {
    logic [3:0]  gnt;
    logic [2:0]  owner;
    logic [15:0] data;
    logic [3:0]  blank;
    logic        sw;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic [63:0] d;

  always #5 clk = ~clk;

  disp_share_arbiter #(.N_REQ(4), .DWELL(8), .DWELL_W(4), .LZ_BLANK(1)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data),
    .gnt(gnt), .owner(owner), .disp_data(disp_data),
    .disp_blank(disp_blank), .switch_p(switch_p)
  );

  // Drive inputs for the next edge and queue what that edge must produce.
  task automatic step(input logic r, input logic [3:0] rq, input logic [63:0] dat,
                      input logic [3:0] eg, input logic [2:0] eo, input logic [15:0] ed,
                      input logic [3:0] eb, input logic es, input string nm);
    exp_t e;
    @(negedge clk);
    rst = r; req = rq; req_data = dat;
    e.gnt = eg; e.owner = eo; e.data = ed; e.blank = eb; e.sw = es; e.name = nm;
    sb.push_back(e);
  endtask

  // Monitor: one registered result per edge, checked just after it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (gnt !== e.gnt || owner !== e.owner || disp_data !== e.data ||
            disp_blank !== e.blank || switch_p !== e.sw) begin
          errors++;
          $display("FAIL %s: got gnt=%b owner=%0d data=%h blank=%b sw=%b, want gnt=%b owner=%0d data=%h blank=%b sw=%b",
                   e.name, gnt, owner, disp_data, disp_blank, switch_p,
                   e.gnt, e.owner, e.data, e.blank, e.sw);
        end
      end
    end
  end

  initial begin
    d = {16'h0BEE, 16'h0000, 16'h00A5, 16'h1000};

    repeat (3) step(1, 4'b0000, d, 4'b0000, 0, 16'h0000, 4'hF, 0, "reset");
    step(0, 4'b0000, d, 4'b0000, 0, 16'h0000, 4'hF, 0, "idle");

    step(0, 4'b0010, d, 4'b0010, 1, 16'h00A5, 4'b1100, 1, "grant1");
    repeat (7) step(0, 4'b1010, d, 4'b0010, 1, 16'h00A5, 4'b1100, 0, "dwell1");
    step(0, 4'b1010, d, 4'b1000, 3, 16'h0BEE, 4'b1000, 1, "rotate3");
    repeat (7) step(0, 4'b1010, d, 4'b1000, 3, 16'h0BEE, 4'b1000, 0, "dwell3");
    step(0, 4'b1010, d, 4'b0010, 1, 16'h00A5, 4'b1100, 1, "wrap1");

    repeat (3) step(0, 4'b0110, d, 4'b0010, 1, 16'h00A5, 4'b1100, 0, "hold1");
    step(0, 4'b0100, d, 4'b0100, 2, 16'h0000, 4'b1110, 1, "release2");
    repeat (7) step(0, 4'b0111, d, 4'b0100, 2, 16'h0000, 4'b1110, 0, "dwell2");
    step(0, 4'b0111, d, 4'b0001, 0, 16'h1000, 4'b0000, 1, "rotate0");

    d[15:0] = 16'h0003;
    step(0, 4'b0001, d, 4'b0001, 0, 16'h0003, 4'b1110, 0, "chg0003");
    d[15:0] = 16'h0300;
    step(0, 4'b0001, d, 4'b0001, 0, 16'h0300, 4'b1000, 0, "chg0300");
    step(0, 4'b0000, d, 4'b0000, 0, 16'h0300, 4'hF, 0, "to_idle");

    step(0, 4'b0100, d, 4'b0100, 2, 16'h0000, 4'b1110, 1, "grant2");
    step(1, 4'b0100, d, 4'b0000, 0, 16'h0000, 4'hF, 0, "rst_mid");
    step(0, 4'b1001, d, 4'b0001, 0, 16'h0300, 4'b1000, 1, "post_rst_rr0");
    step(0, 4'b0000, d, 4'b0000, 0, 16'h0300, 4'hF, 0, "final_idle");

    for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
    if (sb.size() > 0) begin
      errors++;
      $display("FAIL drain: %0d results outstanding, want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
